// File: rtl/inv_final_round_pipe_pkg.sv
// Shared AES inverse-round definitions: state geometry, inverse S-box and InvShiftRows.
// Reused by the inverse middle rounds as well as the inverse final round.
package inv_final_round_pipe_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  // Entry 0 sits in the most significant byte of the table.
  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

  // Byte b is row b%4, column b/4; row r rotates right by r columns.
  function automatic logic [AES_STATE_W-1:0] inv_shift_rows(input logic [AES_STATE_W-1:0] state);
    logic [AES_STATE_W-1:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        res[AES_STATE_W-1-8*(r+4*c) -: 8] = state[AES_STATE_W-1-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/inv_final_round_pipe_inv_substitute4.sv
// One state column through four inverse S-box lookups, captured in the output stage register.
module inv_substitute4
  import inv_final_round_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  logic [31:0] word_d;
  logic [31:0] word_q;

  always_comb begin
    word_d = word_q;
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        word_d[31-8*i -: 8] = inv_sbox(word_in[31-8*i -: 8]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_out = word_q;

endmodule

// File: rtl/inv_final_round_pipe.sv
// First round of the AES-256 equivalent decryption path: out = InvSubBytes(InvShiftRows(in ^ key)).
// Three registered stages under a single global stall; in_ready is the advance signal itself.
module inv_final_round_pipe
  import inv_final_round_pipe_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in,
  input  logic [AES_STATE_W-1:0] key,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out
);

  logic                   adv;
  logic                   s1_v_d, s1_v_q;
  logic                   s2_v_d, s2_v_q;
  logic                   out_valid_d, out_valid_q;
  logic [AES_STATE_W-1:0] s1_data_d, s1_data_q;
  logic [AES_STATE_W-1:0] s2_data_d, s2_data_q;

  // Bubbles may carry garbage data; only the valid bits are meaningful.
  always_comb begin
    adv         = ~out_valid_q | out_ready;
    s1_v_d      = s1_v_q;
    s2_v_d      = s2_v_q;
    out_valid_d = out_valid_q;
    s1_data_d   = s1_data_q;
    s2_data_d   = s2_data_q;
    if (adv) begin
      s1_v_d      = in_valid;
      s2_v_d      = s1_v_q;
      out_valid_d = s2_v_q;
      s1_data_d   = in ^ key;
      s2_data_d   = inv_shift_rows(s1_data_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      out_valid_q <= 1'b0;
      s1_data_q   <= '0;
      s2_data_q   <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s2_v_q      <= s2_v_d;
      out_valid_q <= out_valid_d;
      s1_data_q   <= s1_data_d;
      s2_data_q   <= s2_data_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;

  // Column g holds bytes 4g..4g+3, most significant first.
  for (genvar g = 0; g < 4; g++) begin : g_col
    inv_substitute4 u_col (
      .clk      (clk),
      .rst      (rst),
      .en       (adv),
      .word_in  (s2_data_q[AES_STATE_W-1-32*g -: 32]),
      .word_out (out[AES_STATE_W-1-32*g -: 32])
    );
  end

endmodule

// File: tb/tb_inv_final_round_pipe.sv
// Directed and round-trip checks for inv_final_round_pipe against an algorithmically derived S-box model.
module tb_inv_final_round_pipe;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int n_checks;
  int n_fail;

  logic [7:0] fwd_sbox [256];
  logic [7:0] inv_tab  [256];

  inv_final_round_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_data),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gf_mul(r, a);
    return (a == 8'h00) ? 8'h00 : r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    logic [7:0] y;
    y = x ^ 8'h63;
    for (int k = 1; k <= 4; k++) y = y ^ 8'((x << k) | (x >> (8 - k)));
    return y;
  endfunction

  // Decrypt-side reference: InvSubBytes(InvShiftRows(s ^ k)).
  function automatic logic [127:0] ref_dec(input logic [127:0] s, input logic [127:0] k);
    logic [127:0] t;
    logic [127:0] o;
    t = s ^ k;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = inv_tab[t[127-8*(r+4*((c-r+4)%4)) -: 8]];
    return o;
  endfunction

  // Encrypt final round: AddRoundKey(ShiftRows(SubBytes(x))).
  function automatic logic [127:0] ref_enc(input logic [127:0] x, input logic [127:0] k);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = fwd_sbox[x[127-8*(r+4*((c+r)%4)) -: 8]];
    return o ^ k;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Sends one state into an empty pipe with out_ready high and waits (bounded) for its result.
  task automatic send_one(input logic [127:0] d, input logic [127:0] k, output logic acc,
                          output logic [127:0] obs, output int lat, output logic pulse_ok);
    in_data  = d;
    key      = k;
    in_valid = 1'b1;
    #1;
    acc = in_ready;
    cycle();
    in_valid = 1'b0;
    in_data  = rand128();
    key      = rand128();
    lat = 1;
    while (!out_valid && lat < 10) begin
      cycle();
      lat++;
    end
    obs = out_data;
    cycle();
    pulse_ok = !out_valid;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = rand128();
    key       = rand128();
    out_ready = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (out_data !== 128'h0) begin n_fail++; $display("[TB] FAIL reset_out: got %h expected 0", out_data); end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_no_accept: got out_valid %b expected 0", out_valid); end
    end
  endtask

  task automatic test_zero_vector();
    logic acc, pulse_ok;
    logic [127:0] obs;
    int lat;
    send_one(128'h0, 128'h0, acc, obs, lat, pulse_ok);
    n_checks++;
    if (acc !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_accept: got in_ready %b expected 1", acc); end
    n_checks++;
    if (lat != 3) begin n_fail++; $display("[TB] FAIL zero_latency: got %0d expected 3", lat); end
    n_checks++;
    if (obs !== {16{8'h52}}) begin n_fail++; $display("[TB] FAIL zero_out: got %h expected %h", obs, {16{8'h52}}); end
    n_checks++;
    if (pulse_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_pulse: got out_valid held, expected single cycle"); end
  endtask

  task automatic test_key_cancel();
    logic acc, pulse_ok;
    logic [127:0] obs;
    int lat;
    send_one({16{8'h00}}, {16{8'h63}}, acc, obs, lat, pulse_ok);
    n_checks++;
    if (lat != 3 || obs !== 128'h0) begin n_fail++; $display("[TB] FAIL key_cancel_a: got %h lat %0d expected 0 lat 3", obs, lat); end
    send_one({16{8'h63}}, 128'h0, acc, obs, lat, pulse_ok);
    n_checks++;
    if (lat != 3 || obs !== 128'h0) begin n_fail++; $display("[TB] FAIL key_cancel_b: got %h lat %0d expected 0 lat 3", obs, lat); end
  endtask

  task automatic test_row_shift();
    logic acc, pulse_ok;
    logic [127:0] obs;
    logic [127:0] d;
    logic [127:0] expv;
    int lat;
    d = {16{8'h63}};
    d[119:112] = 8'h00;
    expv = 128'h0;
    expv[87:80] = 8'h52;
    send_one(d, 128'h0, acc, obs, lat, pulse_ok);
    n_checks++;
    if (lat != 3 || obs !== expv) begin n_fail++; $display("[TB] FAIL row_shift: got %h lat %0d expected %h lat 3", obs, lat, expv); end
  endtask

  task automatic test_backpressure();
    logic [127:0] ins [6];
    logic [127:0] keys [6];
    logic [127:0] exp_q [$];
    logic [127:0] prev_out;
    logic [127:0] e;
    logic stalled_prev;
    int sent, got;
    for (int i = 0; i < 6; i++) begin
      ins[i]  = rand128() ^ 128'(i);
      keys[i] = rand128();
    end
    sent = 0;
    got = 0;
    stalled_prev = 1'b0;
    prev_out = '0;
    for (int c = 1; c <= 60 && got < 6; c++) begin
      if (stalled_prev) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== prev_out) begin
          n_fail++;
          $display("[TB] FAIL bp_hold: got valid %b out %h expected valid 1 out %h", out_valid, out_data, prev_out);
        end
      end
      out_ready = !(c >= 4 && c <= 7);
      if (sent < 6) begin
        in_valid = 1'b1;
        in_data  = ins[sent];
        key      = keys[sent];
      end else begin
        in_valid = 1'b0;
        in_data  = rand128();
      end
      #1;
      if (out_valid && !out_ready) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready_stall: got %b expected 0", in_ready); end
      end else if (out_ready) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_in_ready_free: got %b expected 1", in_ready); end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_dec(ins[sent], keys[sent]));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL bp_order: got unexpected output %h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin n_fail++; $display("[TB] FAIL bp_order: got %h expected %h", out_data, e); end
        end
        got++;
      end
      stalled_prev = out_valid && !out_ready;
      prev_out = out_data;
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (got != 6) begin n_fail++; $display("[TB] FAIL bp_count: got %0d results expected 6", got); end
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_duplicate: got out_valid %b expected 0", out_valid); end
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = rand128();
      key      = rand128();
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rmf_accept: got in_ready %b expected 1", in_ready); end
      cycle();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 128'h0) begin
      n_fail++;
      $display("[TB] FAIL rmf_flush: got valid %b out %h expected valid 0 out 0", out_valid, out_data);
    end
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rmf_ghost: got out_valid %b expected 0", out_valid); end
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] orig [$];
    logic [127:0] e;
    logic [127:0] x;
    logic [127:0] k;
    logic have;
    int sent, got;
    sent = 0;
    got = 0;
    have = 1'b0;
    x = '0;
    k = '0;
    for (int c = 0; c < 5000 && got < 1000; c++) begin
      if (!have && sent < 1000) begin
        x = rand128();
        k = rand128();
        have = 1'b1;
      end
      in_valid  = have;
      in_data   = ref_enc(x, k);
      key       = k;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_ready) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rt_in_ready: got %b expected 1", in_ready); end
      end
      if (in_valid && in_ready) begin
        orig.push_back(x);
        sent++;
        have = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (orig.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL rt_state: got unexpected output %h expected none", out_data);
        end else begin
          e = orig.pop_front();
          if (out_data !== e) begin n_fail++; $display("[TB] FAIL rt_state: got %h expected %h", out_data, e); end
        end
        got++;
      end
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (got != 1000) begin n_fail++; $display("[TB] FAIL rt_count: got %0d results expected 1000", got); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) fwd_sbox[i] = affine(gf_inv(8'(i)));
    for (int i = 0; i < 256; i++) inv_tab[fwd_sbox[i]] = 8'(i);
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    key       = '0;
    out_ready = 1'b1;

    test_reset();
    test_zero_vector();
    test_key_cancel();
    test_row_shift();
    test_backpressure();
    test_reset_midflight();
    test_round_trip();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
